// File: rtl/tetris_pkg.sv
// Shared types and defaults for the tetris board block.
// Optional feature macro: TETRIS_GARBAGE_EN (garbage-row insertion).
package tetris_pkg;

  localparam int TETRIS_WIDTH  = 10;
  localparam int TETRIS_HEIGHT = 20;

  typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, DONE, GARB} board_state_e;

  // One piece cell; fields are sized for the largest legal board (16 x 32)
  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } cell_t;

  typedef cell_t [3:0] piece_t;

endpackage

// File: rtl/tetris_row_full.sv
// Row-full detector: a row is full when every column is occupied.
module tetris_row_full #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] row,
  output logic             full
);

  assign full = &row;

endmodule

// File: rtl/tetris_board.sv
// Tetris playfield: locks 4-cell pieces, scans rows bottom-up and collapses
// full rows one at a time, tracks cleared lines and a sticky game-over flag.
// Optional feature macro: TETRIS_GARBAGE_EN adds garbage-row insertion.
module tetris_board
  import tetris_pkg::*;
#(
  parameter int WIDTH  = TETRIS_WIDTH,
  parameter int HEIGHT = TETRIS_HEIGHT,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             lock_valid,
  output logic                             lock_ready,
  input  logic [3:0][$clog2(WIDTH)-1:0]    lock_x,
  input  logic [3:0][$clog2(HEIGHT)-1:0]   lock_y,
`ifdef TETRIS_GARBAGE_EN
  input  logic                             garbage_valid,
  input  logic [$clog2(WIDTH)-1:0]         garbage_hole,
`endif
  output logic [HEIGHT-1:0][WIDTH-1:0]     screen,
  output logic                             busy,
  output logic                             clear_done,
  output logic [CNT_W-1:0]                 lines_cleared,
  output logic                             game_over
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  board_state_e  state, state_nxt;
  piece_t        cap;
  logic [YW-1:0] r;
  logic          row_full;
  logic          legal;

`ifdef TETRIS_GARBAGE_EN
  logic [XW-1:0]    hole;
  logic [WIDTH-1:0] garb_row;

  // Garbage row: every column filled except the requested hole
  always_comb begin
    garb_row       = '1;
    garb_row[hole] = 1'b0;
  end
`endif

  tetris_row_full #(.WIDTH(WIDTH)) u_row_full (
    .row  (screen[r]),
    .full (row_full)
  );

  // Piece legality: all cells on the board and landing on empty squares.
  // Occupancy is tested against the pre-lock board, so duplicate cells are fine.
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (32'(cap[i].x) >= WIDTH || 32'(cap[i].y) >= HEIGHT)
        legal = 1'b0;
      else if (screen[cap[i].y[YW-1:0]][cap[i].x[XW-1:0]])
        legal = 1'b0;
    end
  end

  // State register; reset and start both abort back to IDLE
  always_ff @(posedge clk) begin
    if (reset || start) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt  = state;
    lock_ready = (state == IDLE);
    busy       = (state != IDLE);
    clear_done = (state == DONE);
    case (state)
      IDLE: begin
        if (lock_valid) state_nxt = LOCK;
`ifdef TETRIS_GARBAGE_EN
        else if (garbage_valid) state_nxt = GARB;
`endif
      end
      LOCK:  state_nxt = (game_over || !legal) ? DONE : SCAN;
      SCAN: begin
        if (row_full)                    state_nxt = SHIFT;
        else if (r == YW'(HEIGHT - 1))   state_nxt = DONE;
      end
      SHIFT: state_nxt = SCAN;
      DONE:  state_nxt = IDLE;
`ifdef TETRIS_GARBAGE_EN
      GARB:  state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Board, row pointer, counters and captured request
  always_ff @(posedge clk) begin
    if (reset || start) begin
      screen        <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      r             <= '0;
      cap           <= '0;
`ifdef TETRIS_GARBAGE_EN
      hole          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (lock_valid) begin
            for (int i = 0; i < 4; i++) begin
              cap[i].x <= 5'(lock_x[i]);
              cap[i].y <= 5'(lock_y[i]);
            end
          end
`ifdef TETRIS_GARBAGE_EN
          else if (garbage_valid) hole <= garbage_hole;
`endif
        end
        LOCK: begin
          r <= '0;
          if (!game_over) begin
            if (legal) begin
              for (int i = 0; i < 4; i++)
                screen[cap[i].y[YW-1:0]][cap[i].x[XW-1:0]] <= 1'b1;
            end else begin
              game_over <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (!row_full && r != YW'(HEIGHT - 1)) r <= r + YW'(1);
        end
        SHIFT: begin
          // Collapse rows above r down by one; r stays to catch stacked full rows
          for (int i = 0; i < HEIGHT - 1; i++)
            if (YW'(i) >= r) screen[i] <= screen[i+1];
          screen[HEIGHT-1] <= '0;
          if (~&lines_cleared) lines_cleared <= lines_cleared + CNT_W'(1);
        end
`ifdef TETRIS_GARBAGE_EN
        GARB: begin
          if (|screen[HEIGHT-1]) game_over <= 1'b1;
          for (int i = HEIGHT - 1; i > 0; i--)
            screen[i] <= screen[i-1];
          screen[0] <= garb_row;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_board.sv
// Self-checking bench for tetris_board: directed scenarios with literal
// expectations plus randomized locks checked every cycle against a
// row-list reference model. Garbage tests run when TETRIS_GARBAGE_EN is set.
module tb_tetris_board;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 16;

  logic                clk = 1'b0;
  logic                reset, start, lock_valid;
  logic [3:0][3:0]     lock_x;
  logic [3:0][4:0]     lock_y;
  logic                lock_ready, busy, clear_done, game_over;
  logic [H-1:0][W-1:0] screen;
  logic [CW-1:0]       lines_cleared;
`ifdef TETRIS_GARBAGE_EN
  logic                garbage_valid;
  logic [3:0]          garbage_hole;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tetris_board #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .lock_x        (lock_x),
    .lock_y        (lock_y),
`ifdef TETRIS_GARBAGE_EN
    .garbage_valid (garbage_valid),
    .garbage_hole  (garbage_hole),
`endif
    .screen        (screen),
    .busy          (busy),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] mb [H];
  int  m_lines;
  bit  m_go;
  bit  in_fl;
  int  cyc, exp_lat, acc_cnt;
  bit  chk_en;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [H-1:0][W-1:0] mscr();
    logic [H-1:0][W-1:0] s;
    for (int r = 0; r < H; r++) s[r] = mb[r];
    return s;
  endfunction

  // Whole-lock outcome: legality, cell placement, removal of all full rows
  task automatic model_lock(input logic [3:0][3:0] xs, input logic [3:0][4:0] ys);
    bit ok;
    int k;
    logic [W-1:0] q[$];
    exp_lat = 2;
    if (m_go) return;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (int'(xs[i]) >= W || int'(ys[i]) >= H) ok = 0;
      else if (mb[ys[i]][xs[i]]) ok = 0;
    end
    if (!ok) begin
      m_go = 1;
      return;
    end
    for (int i = 0; i < 4; i++) mb[ys[i]][xs[i]] = 1'b1;
    k = 0;
    for (int r = 0; r < H; r++) begin
      if (mb[r] == {W{1'b1}}) k++;
      else q.push_back(mb[r]);
    end
    for (int r = 0; r < H; r++) mb[r] = (r < q.size()) ? q[r] : '0;
    m_lines = (m_lines + k > 65535) ? 65535 : m_lines + k;
    exp_lat = H + 2 + 2 * k;
  endtask

`ifdef TETRIS_GARBAGE_EN
  task automatic model_garb(input logic [3:0] h);
    logic [W-1:0] g;
    exp_lat = 2;
    if (mb[H-1] != '0) m_go = 1;
    for (int r = H - 1; r > 0; r--) mb[r] = mb[r-1];
    g    = '1;
    g[h] = 1'b0;
    mb[0] = g;
  endtask
`endif

  // Model advance on each rising edge (inputs are stable here)
  always @(posedge clk) begin
    if (reset || start) begin
      for (int r = 0; r < H; r++) mb[r] = '0;
      m_lines = 0;
      m_go    = 0;
      in_fl   = 0;
      cyc     = 0;
    end else if (in_fl) begin
      cyc++;
      if (cyc == exp_lat) in_fl = 0;
    end else if (lock_valid) begin
      model_lock(lock_x, lock_y);
      in_fl = 1;
      cyc   = 0;
      acc_cnt++;
    end
`ifdef TETRIS_GARBAGE_EN
    else if (garbage_valid) begin
      model_garb(garbage_hole);
      in_fl = 1;
      cyc   = 0;
      acc_cnt++;
    end
`endif
  end

  // Compare DUT against model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("lock_ready", 256'(lock_ready), 256'(!in_fl));
      chk("busy", 256'(busy), 256'(in_fl));
      chk("clear_done", 256'(clear_done), 256'(in_fl && cyc == exp_lat - 1));
      if (!in_fl || cyc == exp_lat - 1) begin
        chk("screen", 256'(screen), 256'(mscr()));
        chk("lines_cleared", 256'(lines_cleared), 256'(m_lines));
        chk("game_over", 256'(game_over), 256'(m_go));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_acc(input int a0, output bit ok);
    int n = 0;
    while (acc_cnt == a0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (acc_cnt != a0);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout no handshake within 200 cycles @%0t", $time);
    end
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    lat = -1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (clear_done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout no clear_done within 200 cycles @%0t", $time);
    end
    lock_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_lock(input logic [3:0][3:0] xs, input logic [3:0][4:0] ys,
                           input bit hold, output int lat);
    int a0 = acc_cnt;
    bit ok;
    lock_x = xs;
    lock_y = ys;
    lock_valid = 1'b1;
    wait_acc(a0, ok);
    if (!hold) lock_valid = 1'b0;
    if (!ok) begin
      lat = -1;
      lock_valid = 1'b0;
      return;
    end
    wait_done(lat);
  endtask

  task automatic abort_lock(input logic [3:0][3:0] xs, input logic [3:0][4:0] ys);
    int a0 = acc_cnt;
    bit ok;
    lock_x = xs;
    lock_y = ys;
    lock_valid = 1'b1;
    wait_acc(a0, ok);
    lock_valid = 1'b0;
    repeat ($urandom_range(0, 25)) @(posedge clk);
    #1;
    if ($urandom_range(0, 1) == 1) start = 1'b1;
    else reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
  endtask

`ifdef TETRIS_GARBAGE_EN
  task automatic send_garb(input logic [3:0] h, output int lat);
    int a0 = acc_cnt;
    bit ok;
    garbage_hole  = h;
    garbage_valid = 1'b1;
    wait_acc(a0, ok);
    garbage_valid = 1'b0;
    if (!ok) begin
      lat = -1;
      return;
    end
    wait_done(lat);
  endtask
`endif

  task automatic pulse(input bit use_start);
    if (use_start) start = 1'b1;
    else reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
  endtask

  // Random piece: mostly empty cells in the bottom three rows, with
  // occasional duplicates and occasional arbitrary (possibly illegal) cells
  task automatic rand_piece(output logic [3:0][3:0] xs, output logic [3:0][4:0] ys);
    int p, x, y;
    for (int i = 0; i < 4; i++) begin
      p = $urandom_range(0, 99);
      if (p < 3) begin
        xs[i] = 4'($urandom_range(0, 15));
        ys[i] = 5'($urandom_range(0, 31));
      end else if (p < 10 && i > 0) begin
        xs[i] = xs[i-1];
        ys[i] = ys[i-1];
      end else begin
        x = 0;
        y = 0;
        for (int t = 0; t < 30; t++) begin
          x = $urandom_range(0, W - 1);
          y = $urandom_range(0, 2);
          if (!mb[y][x]) break;
        end
        xs[i] = 4'(x);
        ys[i] = 5'(y);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][3:0]     xs;
    logic [3:0][4:0]     ys;
    logic [H-1:0][W-1:0] s;
    int lat, a0, pulses;
    bit ok;

    reset = 1'b1; start = 1'b0; lock_valid = 1'b0;
    lock_x = '0; lock_y = '0;
`ifdef TETRIS_GARBAGE_EN
    garbage_valid = 1'b0; garbage_hole = '0;
`endif
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_screen", 256'(screen), 256'(0));
    chk("rst_lines", 256'(lines_cleared), 256'(0));
    chk("rst_game_over", 256'(game_over), 256'(0));
    chk("rst_lock_ready", 256'(lock_ready), 256'(1));
    @(posedge clk); #1;

    // Flat piece on the bottom row, no clear
    xs = {4'd3, 4'd2, 4'd1, 4'd0}; ys = '0;
    send_lock(xs, ys, 0, lat);
    chk("t1_lat", 256'(lat), 256'(22));
    chk("t1_row0", 256'(screen[0]), 256'(10'h00F));
    chk("t1_lines", 256'(lines_cleared), 256'(0));

    // Two full rows cleared by a 2x2 piece
    pulse(0);
    ys = '0;
    xs = {4'd5, 4'd4, 4'd3, 4'd2}; send_lock(xs, ys, 0, lat);
    xs = {4'd9, 4'd8, 4'd7, 4'd6}; send_lock(xs, ys, 0, lat);
    ys = {5'd1, 5'd1, 5'd1, 5'd1};
    xs = {4'd5, 4'd4, 4'd3, 4'd2}; send_lock(xs, ys, 0, lat);
    xs = {4'd9, 4'd8, 4'd7, 4'd6}; send_lock(xs, ys, 0, lat);
    xs = {4'd1, 4'd0, 4'd1, 4'd0}; ys = {5'd1, 5'd1, 5'd0, 5'd0};
    send_lock(xs, ys, 0, lat);
    chk("t2_lat", 256'(lat), 256'(26));
    chk("t2_lines", 256'(lines_cleared), 256'(2));
    chk("t2_screen", 256'(screen), 256'(0));

    // Collision with an occupied cell; later lock adds nothing
    pulse(1);
    xs = {4'd5, 4'd5, 4'd5, 4'd5}; ys = '0;
    send_lock(xs, ys, 0, lat);
    chk("t3_dup_lat", 256'(lat), 256'(22));
    xs = {4'd8, 4'd7, 4'd6, 4'd5};
    send_lock(xs, ys, 0, lat);
    chk("t3_lat", 256'(lat), 256'(2));
    chk("t3_game_over", 256'(game_over), 256'(1));
    xs = {4'd3, 4'd2, 4'd1, 4'd0}; ys = {5'd5, 5'd5, 5'd5, 5'd5};
    send_lock(xs, ys, 0, lat);
    s = '0; s[0] = 10'h020;
    chk("t3_after_lat", 256'(lat), 256'(2));
    chk("t3_screen", 256'(screen), 256'(s));

    // start during SHIFT aborts the clear
    pulse(0);
    ys = '0;
    xs = {4'd3, 4'd2, 4'd1, 4'd0}; send_lock(xs, ys, 0, lat);
    xs = {4'd7, 4'd6, 4'd5, 4'd4}; send_lock(xs, ys, 0, lat);
    xs = {4'd1, 4'd0, 4'd9, 4'd8}; ys = {5'd1, 5'd1, 5'd0, 5'd0};
    send_lock(xs, ys, 0, lat);
    chk("t4_clear_lat", 256'(lat), 256'(24));
    chk("t4_lines", 256'(lines_cleared), 256'(1));
    chk("t4_row0", 256'(screen[0]), 256'(10'h003));
    xs = {4'd5, 4'd4, 4'd3, 4'd2}; ys = '0; send_lock(xs, ys, 0, lat);
    xs = {4'd9, 4'd8, 4'd7, 4'd6};
    a0 = acc_cnt;
    lock_x = xs; lock_y = ys; lock_valid = 1'b1;
    wait_acc(a0, ok);
    lock_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4_abort_screen", 256'(screen), 256'(0));
    chk("t4_abort_lines", 256'(lines_cleared), 256'(0));
    chk("t4_abort_ready", 256'(lock_ready), 256'(1));
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (clear_done) pulses++;
    end
    chk("t4_no_done", 256'(pulses), 256'(0));
    @(posedge clk); #1;

    // Out-of-range row with lock_valid held through busy
    pulse(1);
    a0 = acc_cnt;
    xs = {4'd3, 4'd2, 4'd1, 4'd0}; ys = {5'd0, 5'd0, 5'd0, 5'd25};
    send_lock(xs, ys, 1, lat);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_lat", 256'(lat), 256'(2));
    chk("t5_game_over", 256'(game_over), 256'(1));
    chk("t5_accepts", 256'(acc_cnt - a0), 256'(1));
    chk("t5_screen", 256'(screen), 256'(0));

`ifdef TETRIS_GARBAGE_EN
    pulse(0);
    send_garb(4'd3, lat);
    chk("g_lat", 256'(lat), 256'(2));
    chk("g_row0", 256'(screen[0]), 256'(10'h3F7));
    xs = {4'd3, 4'd2, 4'd1, 4'd0}; ys = {5'd19, 5'd19, 5'd19, 5'd19};
    send_lock(xs, ys, 0, lat);
    chk("g_top_lat", 256'(lat), 256'(22));
    send_garb(4'd0, lat);
    chk("g_game_over", 256'(game_over), 256'(1));
`endif

    // Randomized locks, occasional aborts and new games
    pulse(0);
    repeat (250) begin
      if ((m_go && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) < 3)
        pulse(1'($urandom_range(0, 1)));
      rand_piece(xs, ys);
      if ($urandom_range(0, 99) < 6) abort_lock(xs, ys);
      else send_lock(xs, ys, 1'($urandom_range(0, 1)), lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
